pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the five-stage RV32IM pipeline.
- Drives hold and clear controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch/jump flushes, instruction/data memory busywait, and multi-cycle DIV/REM occupancy of EX.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard sources in, stage hold/clear controls and perf counter out.
// The controller side takes master; the pipeline side takes slave.
interface pipeline_hazard_ctrl_if;
   logic        IMEM_BUSYWAIT;
   logic        MEM_BUSYWAIT;
   logic [4:0]  RS1_ADDR_ID;
   logic [4:0]  RS2_ADDR_ID;
   logic        RS1_USED_ID;
   logic        RS2_USED_ID;
   logic        MEM_READ_EN_IDEX;
   logic [4:0]  REG_WRITE_ADDR_IDEX;
   logic        BRANCH_TAKEN_EX;
   logic        DIV_OP_EX;

   logic        PC_STALL;
   logic        IFID_STALL;
   logic        IFID_RESET;
   logic        IDEX_STALL;
   logic        IDEX_RESET;
   logic        EXMEM_STALL;
   logic        EXMEM_RESET;
   logic        MEMWB_STALL;
   logic        DIV_BUSY;
   logic        DIV_DONE;
   logic [31:0] STALL_CNT;

   modport master (
      input  IMEM_BUSYWAIT, MEM_BUSYWAIT, RS1_ADDR_ID, RS2_ADDR_ID, RS1_USED_ID, RS2_USED_ID,
             MEM_READ_EN_IDEX, REG_WRITE_ADDR_IDEX, BRANCH_TAKEN_EX, DIV_OP_EX,
      output PC_STALL, IFID_STALL, IFID_RESET, IDEX_STALL, IDEX_RESET, EXMEM_STALL,
             EXMEM_RESET, MEMWB_STALL, DIV_BUSY, DIV_DONE, STALL_CNT
   );

   modport slave (
      output IMEM_BUSYWAIT, MEM_BUSYWAIT, RS1_ADDR_ID, RS2_ADDR_ID, RS1_USED_ID, RS2_USED_ID,
             MEM_READ_EN_IDEX, REG_WRITE_ADDR_IDEX, BRANCH_TAKEN_EX, DIV_OP_EX,
      input  PC_STALL, IFID_STALL, IFID_RESET, IDEX_STALL, IDEX_RESET, EXMEM_STALL,
             EXMEM_RESET, MEMWB_STALL, DIV_BUSY, DIV_DONE, STALL_CNT
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: controls are combinational (0-cycle) from state and inputs;
// data-memory busywait freezes every stage, DIV/REM holds the front end for DIV_CYCLES-1 cycles.
module pipeline_hazard_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input  logic                    CLK,
   input  logic                    RESET,
   pipeline_hazard_ctrl_if.master  bus
);
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_DIV_WAIT = 1'b1;
   localparam logic [7:0] DIV_LOAD    = 8'(DIV_CYCLES - 2);

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic [7:0]  r_div_cnt;
   logic [7:0]  w_div_cnt_nxt;
   logic [31:0] r_stall_cnt;

   logic w_pc_stall, w_ifid_stall, w_ifid_reset, w_idex_stall, w_idex_reset;
   logic w_exmem_stall, w_exmem_reset, w_memwb_stall, w_div_busy, w_div_done;
   logic w_load_use;

   // rd==x0 never creates a real dependency
   assign w_load_use = bus.MEM_READ_EN_IDEX && (bus.REG_WRITE_ADDR_IDEX != 5'd0) &&
                       ((bus.RS1_USED_ID && (bus.RS1_ADDR_ID == bus.REG_WRITE_ADDR_IDEX)) ||
                        (bus.RS2_USED_ID && (bus.RS2_ADDR_ID == bus.REG_WRITE_ADDR_IDEX)));

   always_comb begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_ifid_reset  = 1'b0;
      w_idex_stall  = 1'b0;
      w_idex_reset  = 1'b0;
      w_exmem_stall = 1'b0;
      w_exmem_reset = 1'b0;
      w_memwb_stall = 1'b0;
      w_div_busy    = 1'b0;
      w_div_done    = 1'b0;
      w_state_nxt   = r_state;
      w_div_cnt_nxt = r_div_cnt;
      if (!RESET) begin
         if (bus.MEM_BUSYWAIT) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
            w_memwb_stall = 1'b1;
            w_div_busy    = (r_state == ST_DIV_WAIT);
         end else if (r_state == ST_DIV_WAIT) begin
            w_div_busy = 1'b1;
            if (r_div_cnt != 8'd0) begin
               w_pc_stall    = 1'b1;
               w_ifid_stall  = 1'b1;
               w_idex_stall  = 1'b1;
               w_exmem_reset = 1'b1;
               w_div_cnt_nxt = r_div_cnt - 8'd1;
            end else begin
               w_div_done  = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end else if (bus.BRANCH_TAKEN_EX) begin
            // flush wins over the wrong-path DIV and load-use; PC still waits on a busy imem
            w_ifid_reset = 1'b1;
            w_idex_reset = 1'b1;
            w_pc_stall   = bus.IMEM_BUSYWAIT;
         end else if (bus.DIV_OP_EX) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_reset = 1'b1;
            w_div_busy    = 1'b1;
            w_state_nxt   = ST_DIV_WAIT;
            w_div_cnt_nxt = DIV_LOAD;
         end else if (w_load_use || bus.IMEM_BUSYWAIT) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_reset = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= ST_RUN;
         r_div_cnt   <= 8'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_cnt_nxt;
         if (w_pc_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.PC_STALL    = w_pc_stall;
   assign bus.IFID_STALL  = w_ifid_stall;
   assign bus.IFID_RESET  = w_ifid_reset;
   assign bus.IDEX_STALL  = w_idex_stall;
   assign bus.IDEX_RESET  = w_idex_reset;
   assign bus.EXMEM_STALL = w_exmem_stall;
   assign bus.EXMEM_RESET = w_exmem_reset;
   assign bus.MEMWB_STALL = w_memwb_stall;
   assign bus.DIV_BUSY    = w_div_busy;
   assign bus.DIV_DONE    = w_div_done;
   assign bus.STALL_CNT   = r_stall_cnt;
endmodule
